// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register file for VGA control/status space with byte strobes and range decode.
// Optional: define VGA_AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module vga_axil_regfile #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       NREGS   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [ADDR_W-1:0]       awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_W-1:0]       araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_W-1:0]       rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic [NREGS-1:0]        reg_wr_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef VGA_AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("vga_axil_regfile: DATA_W must be 32 or 64");
  end

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> OFFS) < ADDR_W'(NREGS);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFFS);
  endfunction

  logic              ready_en_q;
  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  reg_wr_q, reg_wr_d;
  logic              commit;

  assign awready  = ready_en_q & ~aw_full_q;
  assign wready   = ready_en_q & ~w_full_q;
  assign arready  = ready_en_q & ~rvalid_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign reg_wr_o = reg_wr_q;
  assign commit   = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NREGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;

    // Readies are low while a buffer is full, so capture never overlaps commit.
    if (awvalid && awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (in_range(aw_addr_q)) begin
        bresp_d = RESP_OKAY;
        reg_wr_d[idx_of(aw_addr_q)] = 1'b1;
        for (int unsigned l = 0; l < STRB_W; l++) begin
          if (w_strb_q[l]) regs_d[idx_of(aw_addr_q)][l*8 +: 8] = w_data_q[l*8 +: 8];
        end
      end else begin
        bresp_d = RESP_OOR;
      end
    end

    // Reads sample regs_q, so a same-edge commit is not yet visible.
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (arvalid && arready) begin
      rvalid_d = 1'b1;
      if (in_range(araddr)) begin
        rdata_d = regs_q[idx_of(araddr)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_OOR;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      regs_q     <= '{default: RST_VAL};
      reg_wr_q   <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile (DATA_W=32, NREGS=16, RST_VAL=0).
module tb_vga_axil_regfile;

  logic          clk;
  logic          arst_n;
  logic [31:0]   awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [31:0]   araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [511:0]  regs_o;
  logic [15:0]   reg_wr_o;

  int checks = 0;
  int errors = 0;

`ifdef VGA_AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  vga_axil_regfile #(
    .ADDR_W (32),
    .DATA_W (32),
    .NREGS  (16),
    .RST_VAL(32'h0)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .regs_o  (regs_o),
    .reg_wr_o(reg_wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  logic [511:0] exp_regs;

  initial begin
    arst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    exp_regs = '0;

    // Reset state
    tick(); tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_regs", regs_o, '0);
    chk("rst_regwr", reg_wr_o, 16'h0);
    arst_n = 1'b1;
    #1;
    chk("rel_awready_lo", awready, 1'b0);
    tick();
    chk("rel_awready_hi", awready, 1'b1);
    chk("rel_wready_hi", wready, 1'b1);
    chk("rel_arready_hi", arready, 1'b1);

    // 1. Read 0x3C after reset
    araddr = 32'h3C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t1_rvalid", rvalid, 1'b1);
    chk("t1_rdata", rdata, 32'h0);
    chk("t1_rresp", rresp, 2'b00);
    chk("t1_arready_lo", arready, 1'b0);
    tick();
    chk("t1_rvalid_hold", rvalid, 1'b1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("t1_rvalid_clr", rvalid, 1'b0);

    // 2. Same-cycle AW/W to 0x08
    awaddr = 32'h08; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t2_awready_full", awready, 1'b0);
    chk("t2_wready_full", wready, 1'b0);
    chk("t2_bvalid_early", bvalid, 1'b0);
    tick();
    exp_regs[2*32 +: 32] = 32'hDEADBEEF;
    chk("t2_bvalid", bvalid, 1'b1);
    chk("t2_bresp", bresp, 2'b00);
    chk("t2_regs", regs_o, exp_regs);
    chk("t2_regwr", reg_wr_o, 16'h0004);
    tick();
    chk("t2_bvalid_clr", bvalid, 1'b0);
    chk("t2_regwr_clr", reg_wr_o, 16'h0000);
    chk("t2_awready_back", awready, 1'b1);

    // 3. W three cycles ahead of AW, partial strobe
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t3_wready_lo", wready, 1'b0);
    chk("t3_awready_hi", awready, 1'b1);
    tick(); tick();
    chk("t3_no_commit", bvalid, 1'b0);
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t3_bvalid_early", bvalid, 1'b0);
    tick();
    exp_regs[2*32 +: 32] = 32'hDE22BE44;
    chk("t3_reg2", rg(2), 32'hDE22BE44);
    chk("t3_regwr", reg_wr_o, 16'h0004);
    chk("t3_bvalid", bvalid, 1'b1);
    tick();
    chk("t3_bvalid_clr", bvalid, 1'b0);
    // Unaligned read of reg 2
    araddr = 32'h0B; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t3_rd_unaligned", rdata, 32'hDE22BE44);
    tick();
    rready = 1'b0;

    // 4. Out-of-range write and read
    awaddr = 32'h40; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t4_bvalid", bvalid, 1'b1);
    chk("t4_bresp", bresp, EXP_OOR);
    chk("t4_regwr", reg_wr_o, 16'h0000);
    chk("t4_regs", regs_o, exp_regs);
    tick();
    araddr = 32'h40; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t4_rvalid", rvalid, 1'b1);
    chk("t4_rresp", rresp, EXP_OOR);
    chk("t4_rdata", rdata, 32'h0);
    tick();
    rready = 1'b0;

    // 5. bready held low with a second write queued
    bready = 1'b0;
    awaddr = 32'h3C; awvalid = 1'b1; wdata = 32'h000000A5; wstrb = 4'b0001; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_regs[15*32 +: 32] = 32'h000000A5;
    chk("t5_bvalid1", bvalid, 1'b1);
    chk("t5_reg15", regs_o, exp_regs);
    chk("t5_regwr15", reg_wr_o, 16'h8000);
    awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t5_awready_bp", awready, 1'b0);
    chk("t5_wready_bp", wready, 1'b0);
    tick(); tick(); tick();
    chk("t5_bvalid_hold", bvalid, 1'b1);
    chk("t5_no_commit", regs_o, exp_regs);
    chk("t5_regwr_quiet", reg_wr_o, 16'h0000);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t5_bvalid_hs", bvalid, 1'b0);
    tick();
    exp_regs[1*32 +: 32] = 32'h12345678;
    chk("t5_bvalid2", bvalid, 1'b1);
    chk("t5_reg1", regs_o, exp_regs);
    chk("t5_regwr1", reg_wr_o, 16'h0002);
    bready = 1'b1;
    tick();
    chk("t5_bvalid2_clr", bvalid, 1'b0);

    // Read/write collision on reg 1
    awaddr = 32'h04; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h04; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    exp_regs[1*32 +: 32] = 32'hCAFEF00D;
    chk("col_rdata_old", rdata, 32'h12345678);
    chk("col_reg1_new", rg(1), 32'hCAFEF00D);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // 6. Reset while rvalid=1 and AW buffer full
    araddr = 32'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    awaddr = 32'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t6_pre_rvalid", rvalid, 1'b1);
    chk("t6_pre_awfull", awready, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("t6_rvalid", rvalid, 1'b0);
    chk("t6_awready", awready, 1'b0);
    chk("t6_arready", arready, 1'b0);
    chk("t6_bvalid", bvalid, 1'b0);
    chk("t6_rdata", rdata, 32'h0);
    chk("t6_regs", regs_o, '0);
    tick();
    arst_n = 1'b1;
    #1;
    chk("t6_arready_lo", arready, 1'b0);
    tick();
    chk("t6_arready_hi", arready, 1'b1);
    chk("t6_awready_hi", awready, 1'b1);
    // AW buffer must be empty: a lone W may not commit
    wdata = 32'h0000BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    chk("t6_no_stale_aw", bvalid, 1'b0);
    awaddr = 32'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("t6_reg0", rg(0), 32'h0000BEEF);
    chk("t6_regwr0", reg_wr_o, 16'h0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
